uc_jogo_principal_n: RTL and testbench

//  Top-level game controller, parametrised successor of the fixed two-action main UC.

---
 rtl/uc_jogo_principal_n_pkg.sv | 62 ++++++
 rtl/uc_cooldown_canal.sv | 34 +++
 rtl/uc_jogo_principal_n.sv | 166 ++++++++++++++++
 tb/tb_uc_jogo_principal_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_jogo_principal_n_pkg.sv
// Shared definitions for the main game UC and its sibling UCs.
// - estado_t  : state codes, also exported on db_estado for debug
// - saidas_t  : the scalar Moore outputs of the main UC
// - decodifica_saidas : state -> scalar outputs
package uc_jogo_principal_n_pkg;

    localparam int DB_W = 5;

    typedef enum logic [DB_W-1:0] {
        ST_INICIAL           = 5'd0,
        ST_INICIALIZA        = 5'd1,
        ST_ESPERA_JOGADA     = 5'd2,
        ST_REGISTRA          = 5'd3,
        ST_TERMINA_MOV       = 5'd4,
        ST_ESPERA_ACAO       = 5'd5,
        ST_FIM_JOGO          = 5'd6,
        ST_INICIA_ACAO       = 5'd7,
        ST_ESPERA_SALVAMENTO = 5'd8,
        ST_PAUSA             = 5'd9,
        ST_ERRO              = 5'd31
    } estado_t;

    typedef struct packed {
        logic enable_reg_jogada;
        logic reset_reg_jogada;
        logic inicia_movimentacao;
        logic termina;
        logic reset_maquinas;
        logic reset_pontuacao;
        logic pausado;
        logic pronto;
        logic erro_timeout;
    } saidas_t;

    function automatic saidas_t decodifica_saidas(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            ST_INICIALIZA: begin
                s.reset_reg_jogada = 1'b1;
                s.reset_maquinas   = 1'b1;
                s.reset_pontuacao  = 1'b1;
            end
            ST_ESPERA_JOGADA: begin
                s.inicia_movimentacao = 1'b1;
                s.reset_reg_jogada    = 1'b1;
            end
            ST_REGISTRA:    s.enable_reg_jogada = 1'b1;
            ST_TERMINA_MOV: s.termina           = 1'b1;
            ST_PAUSA:       s.pausado           = 1'b1;
            ST_FIM_JOGO: begin
                s.pronto           = 1'b1;
                s.reset_reg_jogada = 1'b1;
                s.reset_maquinas   = 1'b1;
            end
            ST_ERRO:        s.erro_timeout      = 1'b1;
            default:        s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/uc_cooldown_canal.sv
// Per-channel cooldown down-counter.
// Ports: clock, reset (sync, active-high), limpa (clear to zero),
//        carrega (load COOLDOWN, wins over decrement), congela (hold value),
//        zero (counter is zero -> channel not cooling down).
module uc_cooldown_canal #(
    parameter int COOLDOWN = 15,
    parameter int CNT_W    = $clog2(COOLDOWN + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic carrega,
    input  logic congela,
    output logic zero
);

    logic [CNT_W-1:0] conta_r;

    // Cooldown counter: clear, reload, or count down to zero unless frozen
    always_ff @(posedge clock) begin
        if (reset || limpa) begin
            conta_r <= '0;
        end else if (carrega) begin
            conta_r <= CNT_W'(COOLDOWN);
        end else if (!congela && (conta_r != '0)) begin
            conta_r <= conta_r - CNT_W'(1);
        end else begin
            conta_r <= conta_r;
        end
    end

    assign zero = (conta_r == '0);

endmodule

// File: rtl/uc_jogo_principal_n.sv
// Main game control unit with N_ACOES prioritised action channels.
// Inputs : clock, reset (sync, active-high), iniciar, pausar (pulse), vidas,
//          ocorreu_jogada, acao_pedida[N], fim_movimentacao, fim_acao[N]
// Outputs: move-register control, movement control, one-hot inicia_acao[N],
//          machine/score resets, pausado, pronto, erro_timeout, db_estado[5].
// All outputs are registered from the next state, so they follow the
// current state exactly (Moore) without combinational decode on the pins.
module uc_jogo_principal_n
    import uc_jogo_principal_n_pkg::*;
#(
    parameter int                 N_ACOES       = 2,
    parameter int                 COOLDOWN      = 15,
    parameter logic [N_ACOES-1:0] COOLDOWN_MASK = N_ACOES'(2'b10),
    parameter int                 SAVE_WAIT     = 2,
    parameter int                 TIMEOUT       = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               pausar,
    input  logic               vidas,
    input  logic               ocorreu_jogada,
    input  logic [N_ACOES-1:0] acao_pedida,
    input  logic               fim_movimentacao,
    input  logic [N_ACOES-1:0] fim_acao,
    output logic               enable_reg_jogada,
    output logic               reset_reg_jogada,
    output logic               inicia_movimentacao,
    output logic               termina,
    output logic [N_ACOES-1:0] inicia_acao,
    output logic               reset_maquinas,
    output logic               reset_pontuacao,
    output logic               pausado,
    output logic               pronto,
    output logic               erro_timeout,
    output logic [DB_W-1:0]    db_estado
);

    localparam int GRANT_W = (N_ACOES > 1) ? $clog2(N_ACOES) : 1;
    localparam int SAVE_W  = (SAVE_WAIT > 1) ? $clog2(SAVE_WAIT) : 1;
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    estado_t              estado_r, estado_next_s;
    logic [GRANT_W-1:0]   grant_r, grant_next_s, vencedor_s;
    logic [SAVE_W-1:0]    salva_r;
    logic [WD_W-1:0]      wd_r;
    saidas_t              saidas_r;
    logic [N_ACOES-1:0]   inicia_acao_r;
    logic [N_ACOES-1:0]   zero_s, elegivel_s, candidatos_s;
    logic                 ultimo_salv_s, wd_esgotado_s;

    // One cooldown counter per channel; only masked channels ever load
    for (genvar i = 0; i < N_ACOES; i++) begin : g_canal
        uc_cooldown_canal #(.COOLDOWN(COOLDOWN)) u_cooldown (
            .clock   (clock),
            .reset   (reset),
            .limpa   (estado_r == ST_INICIALIZA),
            .carrega ((estado_r == ST_INICIA_ACAO) && (grant_r == GRANT_W'(i)) && COOLDOWN_MASK[i]),
            .congela (estado_r == ST_PAUSA),
            .zero    (zero_s[i])
        );
        assign elegivel_s[i] = ~COOLDOWN_MASK[i] | zero_s[i];
    end

    assign candidatos_s  = acao_pedida & elegivel_s;
    assign ultimo_salv_s = (salva_r == SAVE_W'(SAVE_WAIT - 1));
    assign wd_esgotado_s = (wd_r == WD_W'(TIMEOUT - 1));

    // Fixed-priority arbiter: the highest requesting eligible index wins
    always_comb begin
        vencedor_s = '0;
        for (int i = 0; i < N_ACOES; i++) begin
            vencedor_s = candidatos_s[i] ? GRANT_W'(i) : vencedor_s;
        end
    end

    // Next-state and grant logic
    always_comb begin
        estado_next_s = estado_r;
        grant_next_s  = grant_r;
        case (estado_r)
            ST_INICIAL:  estado_next_s = iniciar ? ST_INICIALIZA : ST_INICIAL;
            ST_INICIALIZA: begin
                estado_next_s = ST_ESPERA_JOGADA;
                grant_next_s  = '0;
            end
            ST_ESPERA_JOGADA: begin
                if (!vidas)              estado_next_s = ST_FIM_JOGO;
                else if (pausar)         estado_next_s = ST_PAUSA;
                else if (ocorreu_jogada) estado_next_s = ST_REGISTRA;
                else                     estado_next_s = ST_ESPERA_JOGADA;
            end
            ST_REGISTRA: estado_next_s = ST_ESPERA_SALVAMENTO;
            ST_ESPERA_SALVAMENTO: begin
                if (!ultimo_salv_s) begin
                    estado_next_s = ST_ESPERA_SALVAMENTO;
                end else if (!vidas) begin
                    estado_next_s = ST_FIM_JOGO;
                end else if (|candidatos_s) begin
                    estado_next_s = ST_TERMINA_MOV;
                    grant_next_s  = vencedor_s;
                end else begin
                    estado_next_s = ST_ESPERA_JOGADA;
                end
            end
            ST_TERMINA_MOV: begin
                // an exit in the timeout cycle still wins over ERRO
                if (fim_movimentacao) estado_next_s = vidas ? ST_INICIA_ACAO : ST_FIM_JOGO;
                else if (wd_esgotado_s) estado_next_s = ST_ERRO;
                else                  estado_next_s = ST_TERMINA_MOV;
            end
            ST_INICIA_ACAO: estado_next_s = ST_ESPERA_ACAO;
            ST_ESPERA_ACAO: begin
                if (fim_acao[grant_r])  estado_next_s = ST_ESPERA_JOGADA;
                else if (wd_esgotado_s) estado_next_s = ST_ERRO;
                else                    estado_next_s = ST_ESPERA_ACAO;
            end
            ST_PAUSA:    estado_next_s = pausar ? ST_ESPERA_JOGADA : ST_PAUSA;
            ST_FIM_JOGO: estado_next_s = iniciar ? ST_INICIALIZA : ST_FIM_JOGO;
            ST_ERRO:     estado_next_s = ST_ERRO;
            default:     estado_next_s = ST_ERRO;
        endcase
    end

    // State, grant and registered Moore outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r      <= ST_INICIAL;
            grant_r       <= '0;
            saidas_r      <= '0;
            inicia_acao_r <= '0;
        end else begin
            estado_r      <= estado_next_s;
            grant_r       <= grant_next_s;
            saidas_r      <= decodifica_saidas(estado_next_s);
            inicia_acao_r <= (estado_next_s == ST_INICIA_ACAO) ?
                             (N_ACOES'(1) << grant_next_s) : '0;
        end
    end

    // Save-wait counter and handshake watchdog; both restart on state entry
    always_ff @(posedge clock) begin
        if (reset) begin
            salva_r <= '0;
            wd_r    <= '0;
        end else begin
            salva_r <= ((estado_r == ST_ESPERA_SALVAMENTO) && (estado_next_s == ST_ESPERA_SALVAMENTO)) ?
                       salva_r + SAVE_W'(1) : '0;
            wd_r    <= (((estado_r == ST_TERMINA_MOV) || (estado_r == ST_ESPERA_ACAO)) &&
                        (estado_next_s == estado_r)) ? wd_r + WD_W'(1) : '0;
        end
    end

    assign enable_reg_jogada   = saidas_r.enable_reg_jogada;
    assign reset_reg_jogada    = saidas_r.reset_reg_jogada;
    assign inicia_movimentacao = saidas_r.inicia_movimentacao;
    assign termina             = saidas_r.termina;
    assign reset_maquinas      = saidas_r.reset_maquinas;
    assign reset_pontuacao     = saidas_r.reset_pontuacao;
    assign pausado             = saidas_r.pausado;
    assign pronto              = saidas_r.pronto;
    assign erro_timeout        = saidas_r.erro_timeout;
    assign inicia_acao         = inicia_acao_r;
    assign db_estado           = estado_r;

endmodule

// File: tb/tb_uc_jogo_principal_n.sv
// Bench for uc_jogo_principal_n: directed scenarios with literal expectations
// plus a randomized phase, all outputs compared every cycle to a model.
module tb_uc_jogo_principal_n;

    localparam int N  = 2;
    localparam int CD = 15;
    localparam int SW = 2;
    localparam int TO = 1023;

    logic       clock = 1'b0;
    logic       reset = 1'b1, iniciar = 1'b0, pausar = 1'b0, vidas = 1'b1;
    logic       ocorreu_jogada = 1'b0, fim_movimentacao = 1'b0;
    logic [1:0] acao_pedida = 2'b00, fim_acao = 2'b00;
    logic       enable_reg_jogada, reset_reg_jogada, inicia_movimentacao, termina;
    logic [1:0] inicia_acao;
    logic       reset_maquinas, reset_pontuacao, pausado, pronto, erro_timeout;
    logic [4:0] db_estado;
    logic [15:0] act_vec;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model: state code, grant, cycles in save/handshake, non-paused cycles since grant
    int m_state = 0, m_grant = 0, m_save = 0, m_wd = 0;
    int m_since[2] = '{CD, CD};
    logic [1:0] mask_v = 2'b10;

    uc_jogo_principal_n #(
        .N_ACOES(N), .COOLDOWN(CD), .COOLDOWN_MASK(2'b10), .SAVE_WAIT(SW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .vidas(vidas),
        .ocorreu_jogada(ocorreu_jogada), .acao_pedida(acao_pedida),
        .fim_movimentacao(fim_movimentacao), .fim_acao(fim_acao),
        .enable_reg_jogada(enable_reg_jogada), .reset_reg_jogada(reset_reg_jogada),
        .inicia_movimentacao(inicia_movimentacao), .termina(termina),
        .inicia_acao(inicia_acao), .reset_maquinas(reset_maquinas),
        .reset_pontuacao(reset_pontuacao), .pausado(pausado), .pronto(pronto),
        .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    assign act_vec = {enable_reg_jogada, reset_reg_jogada, inicia_movimentacao, termina,
                      inicia_acao, reset_maquinas, reset_pontuacao, pausado, pronto,
                      erro_timeout, db_estado};

    initial forever #5 clock = ~clock;

    function automatic logic [15:0] exp_vec(input int s, input int g);
        logic er, rr, im, te, rm, rp, pa, pr, et;
        logic [1:0] ia;
        er = 1'b0; rr = 1'b0; im = 1'b0; te = 1'b0; rm = 1'b0;
        rp = 1'b0; pa = 1'b0; pr = 1'b0; et = 1'b0; ia = 2'b00;
        case (s)
            1:  begin rr = 1'b1; rm = 1'b1; rp = 1'b1; end
            2:  begin im = 1'b1; rr = 1'b1; end
            3:  er = 1'b1;
            4:  te = 1'b1;
            7:  ia[g] = 1'b1;
            9:  pa = 1'b1;
            6:  begin pr = 1'b1; rr = 1'b1; rm = 1'b1; end
            31: et = 1'b1;
            default: ;
        endcase
        return {er, rr, im, te, ia, rm, rp, pa, pr, et, 5'(s)};
    endfunction

    function automatic bit elig(input int i);
        return (mask_v[i] == 1'b0) || (m_since[i] >= CD);
    endfunction

    // advance the model by one clock using the inputs present at the edge
    task automatic model_advance();
        int ns, ng;
        bit [1:0] cand;
        if (reset) begin
            m_state = 0; m_grant = 0; m_save = 0; m_wd = 0;
            m_since[0] = CD; m_since[1] = CD;
            return;
        end
        for (int i = 0; i < 2; i++) cand[i] = acao_pedida[i] && elig(i);
        ns = m_state; ng = m_grant;
        case (m_state)
            0: if (iniciar) ns = 1;
            1: begin ns = 2; ng = 0; end
            2: if (!vidas) ns = 6; else if (pausar) ns = 9; else if (ocorreu_jogada) ns = 3;
            3: ns = 8;
            8: if (m_save == SW - 1) begin
                   if (!vidas) ns = 6;
                   else if (cand != 2'b00) begin ns = 4; ng = cand[1] ? 1 : 0; end
                   else ns = 2;
               end
            4: if (fim_movimentacao) ns = vidas ? 7 : 6; else if (m_wd == TO - 1) ns = 31;
            7: ns = 5;
            5: if (fim_acao[m_grant]) ns = 2; else if (m_wd == TO - 1) ns = 31;
            9: if (pausar) ns = 2;
            6: if (iniciar) ns = 1;
            default: ns = 31;
        endcase
        for (int i = 0; i < 2; i++) if (m_state != 9 && m_since[i] < CD) m_since[i]++;
        if (m_state == 7 && mask_v[m_grant]) m_since[m_grant] = 0;
        if (m_state == 1) begin m_since[0] = CD; m_since[1] = CD; end
        m_save  = (m_state == 8 && ns == 8) ? m_save + 1 : 0;
        m_wd    = ((m_state == 4 || m_state == 5) && ns == m_state) ? m_wd + 1 : 0;
        m_state = ns;
        m_grant = ng;
    endtask

    task automatic step();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            tests++;
            if (act_vec !== exp_vec(m_state, m_grant)) begin
                fails++;
                $display("FAIL model_cmp: got %h expected %h (model state %0d) at %0t",
                         act_vec, exp_vec(m_state, m_grant), m_state, $time);
            end
        end
    end

    task automatic grant_ch1();
        acao_pedida = 2'b10; ocorreu_jogada = 1'b1; step(); ocorreu_jogada = 1'b0;
        step(); step(); step();
        chk("grant_ch1_tm", int'(db_estado), 4);
        fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
        chk("grant_ch1_pulse", int'(inicia_acao), 2);
        step(); fim_acao = 2'b10; step(); fim_acao = 2'b00;
        chk("grant_ch1_back", int'(db_estado), 2);
    endtask

    task automatic probe(input string name, input int w, input bit paused, input int exp);
        if (paused) begin
            pausar = 1'b1; step(); pausar = 1'b0;
            repeat (9) step();
            pausar = 1'b1; step(); pausar = 1'b0;
        end
        repeat (w) step();
        ocorreu_jogada = 1'b1; step(); ocorreu_jogada = 1'b0;
        step(); step(); step();
        chk(name, int'(db_estado), exp);
        if (exp == 4) begin
            fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
            chk({name, "_pulse"}, int'(inicia_acao), 2);
            step(); fim_acao = 2'b10; step(); fim_acao = 2'b00;
        end
    endtask

    task automatic move_to_tm();
        ocorreu_jogada = 1'b1; step(); ocorreu_jogada = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        // reset
        step(); chk_en = 1'b1; step();
        chk("reset_outs", int'(act_vec), 0);
        reset = 1'b0;

        // 1: move with no action request
        iniciar = 1'b1; step(); iniciar = 1'b0;
        chk("t1_inicializa", int'(db_estado), 1);
        chk("t1_reset_pont", int'(reset_pontuacao), 1);
        ocorreu_jogada = 1'b1; step(); chk("t1_espera", int'(db_estado), 2);
        step(); ocorreu_jogada = 1'b0; chk("t1_registra", int'(db_estado), 3);
        step(); chk("t1_salv_a", int'(db_estado), 8);
        step(); chk("t1_salv_b", int'(db_estado), 8);
        step(); chk("t1_back", int'(db_estado), 2);
        chk("t1_no_pulse", int'(inicia_acao), 0);

        // 2: priority, then cooldown blocks ch1
        acao_pedida = 2'b11; move_to_tm();
        chk("t2_tm", int'(db_estado), 4);
        fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
        chk("t2_pulse_ch1", int'(inicia_acao), 2);
        step(); chk("t2_pulse_gone", int'(inicia_acao), 0);
        fim_acao = 2'b01; step(); chk("t2_other_fim_ignored", int'(db_estado), 5);
        fim_acao = 2'b10; step(); fim_acao = 2'b00;
        chk("t2_back", int'(db_estado), 2);
        repeat (4) step();
        move_to_tm();
        fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
        chk("t2_pulse_ch0", int'(inicia_acao), 1);
        step(); fim_acao = 2'b01; step(); fim_acao = 2'b00;

        // 3: cooldown expiry and pause freeze
        repeat (20) step();
        grant_ch1();
        probe("t3_cd_not_yet", 10, 1'b0, 2);
        grant_ch1();
        probe("t3_cd_expired", 11, 1'b0, 4);
        probe("t3_pause_not_yet", 9, 1'b1, 2);
        grant_ch1();
        probe("t3_pause_expired", 10, 1'b1, 4);

        // 4: watchdog
        acao_pedida = 2'b01; move_to_tm();
        repeat (TO - 1) step();
        chk("t4_still_tm", int'(db_estado), 4);
        step();
        chk("t4_erro", int'(db_estado), 31);
        chk("t4_erro_flag", int'(erro_timeout), 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t4_reset", int'(db_estado), 0);
        iniciar = 1'b1; step(); iniciar = 1'b0; step();
        move_to_tm();
        repeat (TO - 1) step();
        fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
        chk("t4_exit_wins", int'(db_estado), 7);
        step(); fim_acao = 2'b01; step(); fim_acao = 2'b00;

        // 5: game over and restart
        vidas = 1'b0; step(); vidas = 1'b1;
        chk("t5_fim", int'(db_estado), 6);
        chk("t5_pronto", int'(pronto), 1);
        iniciar = 1'b1; step(); iniciar = 1'b0;
        chk("t5_restart", int'(db_estado), 1);
        chk("t5_reset_pont", int'(reset_pontuacao), 1);
        step();

        // 6: reset mid-handshake
        acao_pedida = 2'b10; move_to_tm();
        fim_movimentacao = 1'b1; step(); fim_movimentacao = 1'b0;
        step();
        fim_acao = 2'b01; step(); fim_acao = 2'b00;
        chk("t6_wait_own_fim", int'(db_estado), 5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_reset_outs", int'(act_vec), 0);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            reset            = ($urandom_range(0, 99) == 0);
            iniciar          = ($urandom_range(0, 3) == 0);
            pausar           = ($urandom_range(0, 7) == 0);
            vidas            = ($urandom_range(0, 19) != 0);
            ocorreu_jogada   = ($urandom_range(0, 2) == 0);
            acao_pedida      = 2'($urandom_range(0, 3));
            fim_movimentacao = ($urandom_range(0, 2) == 0);
            fim_acao         = 2'($urandom_range(0, 3));
            step();
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
